// File: rtl/uart_rx_frame_pkg.sv
// Shared state encoding and parity-type constants for the UART receive framer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Bundle between the RX edge detector / consumer side and the receive framer.
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_in;
    logic                  start;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  parity_err;
    logic                  stop_err;
    logic                  busy;

    modport master (
        output rx_in, start,
        input  data_out, data_valid, parity_err, stop_err, busy
    );

    modport slave (
        input  rx_in, start,
        output data_out, data_valid, parity_err, stop_err, busy
    );
endinterface

// File: rtl/uart_rx_frame_bit_timer.sv
// Per-bit oversampling counter for the UART framer; flags mid-bit and end-of-bit cycles.
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clr_i,
    input  logic run_i,
    output logic mid_tick_o,
    output logic end_tick_o
);
    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign mid_tick_o = (cnt_q == CW'(PRESCALE / 2));
    assign end_tick_o = (cnt_q == CW'(PRESCALE - 1));

    // Load to 1: the cycle the start pulse is seen already counts as cnt=0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CW'(1);
        end else if (run_i) begin
            cnt_d = end_tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start validation, LSB-first shift, stop check, one-cycle result strobe.
// Optional parity bit compiled in with UART_RX_PARITY_EN.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESCALE    = 16,
    parameter int PARITY_TYPE = 0
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_frame_if.slave  rx_if
);
    localparam int BW = $clog2(DATA_WIDTH);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || PRESCALE < 4 || (PRESCALE % 2) != 0 ||
        (PARITY_TYPE != PARITY_EVEN && PARITY_TYPE != PARITY_ODD)) begin : g_bad_param
        $error("uart_rx_frame: unsupported parameter set");
    end

    rx_state_e             state_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  stop_err_q;
    logic                  mid_tick;
    logic                  end_tick;
    logic                  idle;

`ifdef UART_RX_PARITY_EN
    logic                  par_bit_q;
    logic                  par_err_q;
`endif

    assign idle = (state_q == IDLE);

    uart_rx_bit_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (idle && rx_if.start),
        .clr_i      (idle && !rx_if.start),
        .run_i      (!idle),
        .mid_tick_o (mid_tick),
        .end_tick_o (end_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            stop_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
`endif
        end else begin
            valid_q    <= 1'b0;
            stop_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (rx_if.start) begin
                        state_q <= START;
                        bit_q   <= '0;
                    end
                end
                START: begin
                    if (mid_tick && rx_if.rx_in) begin
                        state_q <= IDLE;
                    end else if (end_tick) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (mid_tick) begin
                        shift_q <= {rx_if.rx_in, shift_q[DATA_WIDTH-1:1]};
                    end
                    if (end_tick) begin
                        if (bit_q == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_tick) begin
                        par_bit_q <= rx_if.rx_in;
                    end
                    if (end_tick) begin
                        state_q <= STOP;
                    end
                end
`endif
                // Leave at mid-stop so the next start edge is never missed.
                STOP: begin
                    if (mid_tick) begin
                        state_q    <= IDLE;
                        data_q     <= shift_q;
                        valid_q    <= 1'b1;
                        stop_err_q <= ~rx_if.rx_in;
`ifdef UART_RX_PARITY_EN
                        par_err_q  <= ((^shift_q) ^ 1'(PARITY_TYPE)) != par_bit_q;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.stop_err   = stop_err_q;
    assign rx_if.busy       = !idle;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = par_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif
endmodule
